// File: rtl/sys_cntr_tx.sv
// Response-side system controller: serialises register reads and ALU results into UART Tx bytes.
// Optional build macro SYS_CNTR_TX_TAG_EN prefixes each frame with a tag byte (0xBB read, 0xCC ALU).
module sys_cntr_tx #(
    parameter int unsigned width = 8
) (
    input  logic                 CLK,
    input  logic                 Reset,
    input  logic [width-1:0]     RdData,
    input  logic                 RdData_Valid,
    input  logic [2*width-1:0]   ALU_OUT,
    input  logic                 ALU_Valid,
    output logic [width-1:0]     Tx_P_Data,
    output logic                 Tx_Valid,
    input  logic                 Tx_Ready,
    output logic                 Busy,
    output logic                 Overrun
);

`ifdef SYS_CNTR_TX_TAG_EN
    typedef enum logic [2:0] {IDLE, TAG, RD_BYTE, ALU_LO, ALU_HI} state_t;
    localparam logic [width-1:0] TAG_RD  = width'(8'hBB);
    localparam logic [width-1:0] TAG_ALU = width'(8'hCC);
    logic frame_alu;
`else
    typedef enum logic [1:0] {IDLE, RD_BYTE, ALU_LO, ALU_HI} state_t;
`endif

    state_t               state;
    logic [width-1:0]     rd_buf;
    logic [2*width-1:0]   alu_buf;
    logic                 rd_pend, alu_pend;

    logic xfer, rd_done, alu_done;
    logic rd_take, alu_take;
    logic rd_pend_nxt, alu_pend_nxt;

    // A source's pending slot frees on the edge its final byte is accepted, so a
    // strobe on that very edge is captured rather than dropped.
    assign xfer         = Tx_Valid & Tx_Ready;
    assign rd_done      = xfer & (state == RD_BYTE);
    assign alu_done     = xfer & (state == ALU_HI);
    assign rd_take      = RdData_Valid & (~rd_pend | rd_done);
    assign alu_take     = ALU_Valid & (~alu_pend | alu_done);
    assign rd_pend_nxt  = rd_take | (rd_pend & ~rd_done);
    assign alu_pend_nxt = alu_take | (alu_pend & ~alu_done);

    always_ff @(posedge CLK or posedge Reset) begin
        if (Reset) begin
            state     <= IDLE;
            rd_buf    <= '0;
            alu_buf   <= '0;
            rd_pend   <= 1'b0;
            alu_pend  <= 1'b0;
            Tx_P_Data <= '0;
            Tx_Valid  <= 1'b0;
            Busy      <= 1'b0;
            Overrun   <= 1'b0;
`ifdef SYS_CNTR_TX_TAG_EN
            frame_alu <= 1'b0;
`endif
        end else begin
            Overrun  <= (RdData_Valid & ~rd_take) | (ALU_Valid & ~alu_take);
            Busy     <= rd_pend_nxt | alu_pend_nxt | ((state != IDLE) & ~rd_done & ~alu_done);
            rd_pend  <= rd_pend_nxt;
            alu_pend <= alu_pend_nxt;
            if (rd_take)  rd_buf  <= RdData;
            if (alu_take) alu_buf <= ALU_OUT;

            // Each byte state raises Tx_Valid once, then drops it for a cycle after the transfer.
            case (state)
                IDLE: begin
                    if (alu_pend) begin
                        Tx_Valid  <= 1'b1;
`ifdef SYS_CNTR_TX_TAG_EN
                        state     <= TAG;
                        frame_alu <= 1'b1;
                        Tx_P_Data <= TAG_ALU;
`else
                        state     <= ALU_LO;
                        Tx_P_Data <= alu_buf[width-1:0];
`endif
                    end else if (rd_pend) begin
                        Tx_Valid  <= 1'b1;
`ifdef SYS_CNTR_TX_TAG_EN
                        state     <= TAG;
                        frame_alu <= 1'b0;
                        Tx_P_Data <= TAG_RD;
`else
                        state     <= RD_BYTE;
                        Tx_P_Data <= rd_buf;
`endif
                    end
                end
`ifdef SYS_CNTR_TX_TAG_EN
                TAG: begin
                    if (xfer) begin
                        Tx_Valid <= 1'b0;
                        state    <= frame_alu ? ALU_LO : RD_BYTE;
                    end
                end
`endif
                RD_BYTE: begin
                    if (!Tx_Valid) begin
                        Tx_Valid  <= 1'b1;
                        Tx_P_Data <= rd_buf;
                    end else if (Tx_Ready) begin
                        Tx_Valid <= 1'b0;
                        state    <= IDLE;
                    end
                end
                ALU_LO: begin
                    if (!Tx_Valid) begin
                        Tx_Valid  <= 1'b1;
                        Tx_P_Data <= alu_buf[width-1:0];
                    end else if (Tx_Ready) begin
                        Tx_Valid <= 1'b0;
                        state    <= ALU_HI;
                    end
                end
                ALU_HI: begin
                    if (!Tx_Valid) begin
                        Tx_Valid  <= 1'b1;
                        Tx_P_Data <= alu_buf[2*width-1:width];
                    end else if (Tx_Ready) begin
                        Tx_Valid <= 1'b0;
                        state    <= IDLE;
                    end
                end
                default: begin
                    Tx_Valid <= 1'b0;
                    state    <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_sys_cntr_tx.sv
// Bench for sys_cntr_tx: directed scenarios plus randomized strobe bursts against a frame-level model.
module tb_sys_cntr_tx;
    localparam int unsigned W = 8;

    logic           CLK = 1'b0;
    logic           Reset;
    logic [W-1:0]   RdData;
    logic           RdData_Valid;
    logic [2*W-1:0] ALU_OUT;
    logic           ALU_Valid;
    logic [W-1:0]   Tx_P_Data;
    logic           Tx_Valid;
    logic           Tx_Ready;
    logic           Busy;
    logic           Overrun;

    sys_cntr_tx #(.width(W)) dut (
        .CLK(CLK), .Reset(Reset),
        .RdData(RdData), .RdData_Valid(RdData_Valid),
        .ALU_OUT(ALU_OUT), .ALU_Valid(ALU_Valid),
        .Tx_P_Data(Tx_P_Data), .Tx_Valid(Tx_Valid), .Tx_Ready(Tx_Ready),
        .Busy(Busy), .Overrun(Overrun)
    );

    always #5 CLK = ~CLK;

    int total = 0;
    int bad   = 0;
    logic [7:0] got[$];
    logic [7:0] exp_q[$];
    int ovr_cnt, exp_ovr, vhi_cnt;
    logic prev_v = 1'b0, prev_r = 1'b0, prev_x = 1'b0;
    logic [7:0] prev_d = '0;

    task automatic check(input string tag, input logic [31:0] act, input logic [31:0] req);
        total++;
        if (act !== req) begin
            bad++;
            $display("FAIL %s act=%0h req=%0h", tag, act, req);
        end
    endtask

    // Observe the byte stream and handshake rules away from the active edge.
    always @(negedge CLK) begin
        if (Reset) begin
            prev_v = 1'b0; prev_r = 1'b0; prev_x = 1'b0;
        end else begin
            if (prev_v && !prev_r) begin
                check("hold_valid", 32'(Tx_Valid), 32'(1));
                check("hold_data", 32'(Tx_P_Data), 32'(prev_d));
            end
            if (prev_x) check("gap_after_xfer", 32'(Tx_Valid), 32'(0));
            if (Overrun) ovr_cnt++;
            if (Tx_Valid) vhi_cnt++;
            if (Tx_Valid && Tx_Ready) got.push_back(Tx_P_Data);
            prev_v = Tx_Valid;
            prev_r = Tx_Ready;
            prev_x = Tx_Valid && Tx_Ready;
            prev_d = Tx_P_Data;
        end
    end

    task automatic tick;
        @(posedge CLK);
        #1;
    endtask

    task automatic clear_obs;
        got.delete();
        exp_q.delete();
        ovr_cnt = 0;
        exp_ovr = 0;
        vhi_cnt = 0;
    endtask

    // Frame model: optional tag byte, then payload LSB first.
    function automatic void add_rd(input logic [7:0] d);
`ifdef SYS_CNTR_TX_TAG_EN
        exp_q.push_back(8'hBB);
`endif
        exp_q.push_back(d);
    endfunction

    function automatic void add_alu(input logic [15:0] v);
`ifdef SYS_CNTR_TX_TAG_EN
        exp_q.push_back(8'hCC);
`endif
        exp_q.push_back(v[7:0]);
        exp_q.push_back(v[15:8]);
    endfunction

    task automatic strobe(input bit r, input logic [7:0] rd, input bit a, input logic [15:0] al);
        RdData = rd; RdData_Valid = r;
        ALU_OUT = al; ALU_Valid = a;
        tick();
        RdData_Valid = 1'b0;
        ALU_Valid = 1'b0;
    endtask

    task automatic wait_idle(input string tag);
        int n = 0;
        while (Busy && n < 500) begin
            tick();
            n++;
        end
        if (n >= 500) check({tag, "_timeout"}, 32'(Busy), 32'(0));
    endtask

    task automatic compare(input string tag, input bit full_rate);
        check({tag, "_len"}, 32'(got.size()), 32'(exp_q.size()));
        for (int i = 0; i < exp_q.size(); i++)
            if (i < got.size()) check({tag, "_byte"}, 32'(got[i]), 32'(exp_q[i]));
        check({tag, "_ovr"}, 32'(ovr_cnt), 32'(exp_ovr));
        if (full_rate) check({tag, "_valid_cycles"}, 32'(vhi_cnt), 32'(exp_q.size()));
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog total=%0d bad=%0d", total, bad);
        $fatal(1);
    end

    initial begin
        int n;
        bit have_r, have_a, alu_first, r, a;
        logic [7:0] rv, d;
        logic [15:0] av, v;
        int k;

        Reset = 1'b1; RdData = '0; RdData_Valid = 1'b0; ALU_OUT = '0; ALU_Valid = 1'b0; Tx_Ready = 1'b0;
        tick(); tick();
        check("rst_valid", 32'(Tx_Valid), 32'(0));
        check("rst_busy", 32'(Busy), 32'(0));
        check("rst_ovr", 32'(Overrun), 32'(0));
        check("rst_data", 32'(Tx_P_Data), 32'(0));
        Reset = 1'b0;
        tick();

        // Single read, full rate: 2-cycle latency, Busy drops right after the last transfer.
        clear_obs(); Tx_Ready = 1'b1;
        add_rd(8'h5A);
        strobe(1, 8'h5A, 0, 16'h0);
        check("rd_lat1", 32'(Tx_Valid), 32'(0));
        check("rd_busy", 32'(Busy), 32'(1));
        tick();
        check("rd_lat2", 32'(Tx_Valid), 32'(1));
        check("rd_first", 32'(Tx_P_Data), 32'(exp_q[0]));
        n = 0;
        while (got.size() < exp_q.size() && n < 100) begin
            @(negedge CLK); #1; n++;
        end
        if (n >= 100) check("rd_timeout", 32'(got.size()), 32'(exp_q.size()));
        @(posedge CLK); #1;
        check("rd_busy_low", 32'(Busy), 32'(0));
        compare("rd", 1);

        // ALU result held under 10 cycles of backpressure.
        clear_obs(); Tx_Ready = 1'b0;
        add_alu(16'h1234);
        strobe(0, 8'h0, 1, 16'h1234);
        tick();
        for (int i = 0; i < 10; i++) begin
            check("bp_valid", 32'(Tx_Valid), 32'(1));
            check("bp_data", 32'(Tx_P_Data), 32'(exp_q[0]));
            tick();
        end
        Tx_Ready = 1'b1;
        wait_idle("bp");
        compare("bp", 0);

        // Simultaneous strobes: ALU frame first.
        clear_obs(); Tx_Ready = 1'b1;
        add_alu(16'hBEEF); add_rd(8'h77);
        strobe(1, 8'h77, 1, 16'hBEEF);
        wait_idle("sim");
        compare("sim", 1);

        // Second ALU strobe while the first is pending is dropped.
        clear_obs(); Tx_Ready = 1'b0;
        add_alu(16'h0001);
        strobe(0, 8'h0, 1, 16'h0001);
        tick(); tick();
        strobe(0, 8'h0, 1, 16'h0002);
        exp_ovr = 1;
        tick(); tick(); tick();
        Tx_Ready = 1'b1;
        wait_idle("ovr");
        compare("ovr", 0);

        // Reset in the middle of an ALU frame.
        clear_obs(); Tx_Ready = 1'b1;
        strobe(0, 8'h0, 1, 16'hA5C3);
        n = 0;
        while (!(got.size() > 0 && got[got.size()-1] == 8'hC3) && n < 100) begin
            @(negedge CLK); #1; n++;
        end
        if (n >= 100) check("rst_mid_timeout", 32'(got.size()), 32'(1));
        tick(); tick();
        #1 Reset = 1'b1;
        #1;
        check("rst_mid_valid", 32'(Tx_Valid), 32'(0));
        check("rst_mid_busy", 32'(Busy), 32'(0));
        check("rst_mid_ovr", 32'(Overrun), 32'(0));
        tick();
        Reset = 1'b0;
        clear_obs();
        repeat (20) tick();
        check("rst_quiet_len", 32'(got.size()), 32'(0));
        check("rst_quiet_busy", 32'(Busy), 32'(0));

        // Back-to-back reads four cycles apart.
        clear_obs(); Tx_Ready = 1'b1;
        add_rd(8'h01); add_rd(8'h02);
        strobe(1, 8'h01, 0, 16'h0);
        tick(); tick(); tick();
        strobe(1, 8'h02, 0, 16'h0);
        wait_idle("b2b");
        compare("b2b", 1);

        // Read strobe landing on the final-transfer edge of a read frame is kept.
        clear_obs(); Tx_Ready = 1'b1;
        add_rd(8'h10); add_rd(8'h20);
        strobe(1, 8'h10, 0, 16'h0);
        n = 0;
        while (!(Tx_Valid && Tx_P_Data == 8'h10) && n < 50) begin
            tick(); n++;
        end
        if (n >= 50) check("edge_timeout", 32'(Tx_P_Data), 32'(8'h10));
        strobe(1, 8'h20, 0, 16'h0);
        wait_idle("edge");
        compare("edge", 1);

        // Randomized bursts with backpressure: first source to strobe is sent first,
        // repeat strobes to a pending source are dropped with an Overrun pulse.
        for (int t = 0; t < 40; t++) begin
            clear_obs(); Tx_Ready = 1'b0;
            have_r = 0; have_a = 0; alu_first = 0; rv = '0; av = '0;
            k = int'($urandom_range(1, 4));
            for (int c = 0; c < k; c++) begin
                r = 1'($urandom); a = 1'($urandom);
                if (c == 0 && !r && !a) r = 1;
                d = 8'($urandom); v = 16'($urandom);
                if ((r && have_r) || (a && have_a)) exp_ovr++;
                if (!have_r && !have_a) alu_first = a;
                if (r && !have_r) begin have_r = 1; rv = d; end
                if (a && !have_a) begin have_a = 1; av = v; end
                strobe(r, d, a, v);
            end
            if (alu_first) begin
                add_alu(av);
                if (have_r) add_rd(rv);
            end else begin
                add_rd(rv);
                if (have_a) add_alu(av);
            end
            repeat ($urandom_range(0, 3)) tick();
            n = 0;
            while (Busy && n < 300) begin
                Tx_Ready = ($urandom_range(0, 3) != 0);
                tick(); n++;
            end
            if (n >= 300) check("rnd_timeout", 32'(Busy), 32'(0));
            Tx_Ready = 1'b0;
            tick();
            compare("rnd", 0);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule

// File: doc/sys_cntr_tx.md
Name: sys_cntr_tx

Overview:
Response-side system controller.
- Collects register-file read data and ALU results.
- Serialises them into byte frames for the UART transmit path, over a valid/ready byte handshake.
- Sits between the register file / ALU and the UART Tx (or its synchroniser FIFO).
- Mirrors the command-side controller: every read or ALU command issued there produces exactly one response frame here.

Parameters:
- width, 8, data byte width; register-file data width; ALU result is 2*width.

Ports:
- CLK  in  1  system clock.
- Reset  in  1  asynchronous, active-high reset.
- RdData  in  width  register-file read data.
- RdData_Valid  in  1  one-cycle strobe; RdData valid this cycle.
- ALU_OUT  in  2*width  ALU result.
- ALU_Valid  in  1  one-cycle strobe; ALU_OUT valid this cycle.
- Tx_P_Data  out  width  byte to transmit.
- Tx_Valid  out  1  Tx_P_Data valid.
- Tx_Ready  in  1  downstream accepts the byte; a transfer occurs when Tx_Valid and Tx_Ready are both high on a rising CLK edge.
- Busy  out  1  frame in progress or result pending.
- Overrun  out  1  one-cycle pulse when a result is dropped.

Behaviour:
- Reset (async, active-high): state=IDLE; pending flags cleared; Tx_P_Data=0, Tx_Valid=0, Busy=0, Overrun=0. Reset mid-frame aborts the frame; the partial frame is not resumed.
- Capture:
  - On RdData_Valid, RdData is latched into rd_buf and rd_pend=1.
  - On ALU_Valid, ALU_OUT is latched into alu_buf and alu_pend=1.
  - Both strobes in the same cycle: both are captured.
- Overrun: a strobe arriving while the same source's pend=1 and that buffer is not the frame currently being sent:
  - the new value is dropped and the old one is kept;
  - Overrun pulses for 1 cycle the following cycle.
- FSM states: IDLE, RD_BYTE, ALU_LO, ALU_HI.
- IDLE:
  - if alu_pend → ALU_LO; else if rd_pend → RD_BYTE. ALU has priority.
  - Tx_Valid rises the cycle after the transition decision (registered). Minimum latency from strobe to Tx_Valid is 2 cycles.
- RD_BYTE: Tx_P_Data=rd_buf. On transfer: rd_pend=0, → IDLE.
- ALU_LO: Tx_P_Data=alu_buf[width-1:0]. On transfer → ALU_HI.
- ALU_HI: Tx_P_Data=alu_buf[2*width-1:width]. On transfer: alu_pend=0, → IDLE.
- Handshake:
  - Tx_Valid stays high and Tx_P_Data stays stable until transfer; no retraction.
  - After each transfer, Tx_Valid drops for at least 1 cycle before the next byte.
  - Tx_Ready high while Tx_Valid is low has no effect.
- Byte order: little-endian (LSB first).
- A strobe for the source whose frame is in flight is captured only after its pend flag clears. If the strobe coincides with the final transfer edge, the new value is captured and pend stays 1.
- Busy = (state != IDLE) | rd_pend | alu_pend. Busy is used to hold the command-side clock gate / block new commands.
- No arithmetic; width slicing only.

Optional Feature:
- Macro: SYS_CNTR_TX_TAG_EN.
- Defined:
  - Each frame is prefixed by a tag byte: 0xBB for a read response, 0xCC for an ALU response.
  - This adds a TAG state entered from IDLE, with the same handshake rules.
  - The read frame becomes 2 bytes and the ALU frame 3 bytes.
- Undefined: no TAG state; frames are 1 or 2 bytes as above.

Test Plan:
- Read response: RdData=0x5A strobe, Tx_Ready=1 → exactly one transfer of 0x5A; Busy low 1 cycle after the transfer. With TAG_EN: 0xBB then 0x5A.
- ALU response with backpressure: ALU_OUT=0x1234, Tx_Ready held 0 for 10 cycles then 1 → Tx_Valid held with 0x34 stable for all 10 cycles; then 0x34, 0x12 transferred; no other bytes.
- Simultaneous strobes: RdData=0x77 and ALU_OUT=0xBEEF in the same cycle → byte sequence 0xEF, 0xBE, 0x77; Overrun never pulses.
- Overrun: ALU_OUT=0x0001 strobe, Tx_Ready=0; second ALU strobe 0x0002 → Overrun pulses once; after Tx_Ready=1 the bytes are 0x01, 0x00 only.
- Reset mid-frame: ALU_OUT=0xA5C3, Reset asserted after the 0xC3 transfer → Tx_Valid, Busy and Overrun are 0 immediately (async). After release no bytes are sent until a new strobe.
- Back-to-back reads: RdData strobes 0x01, 0x02 spaced 4 cycles apart, Tx_Ready=1 → 0x01 then 0x02, each Tx_Valid high exactly 1 cycle with at least 1 low cycle between.
